// File: rtl/prog_loader.sv
// Boot-time program loader: streams a length-prefixed, XOR-checksummed image into
// instruction memory and keeps the CPU in reset until the image has been verified.
module prog_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int          WI        = ADDR_WIDTH - 1;
    localparam logic [16:0] MAX_WORDS = 17'(2 ** (ADDR_WIDTH - 2));

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, DONE, ERROR} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [WI-1:0]           count_q, count_d;
    logic [WI-1:0]           word_idx_q, word_idx_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [23:0]             asm_q, asm_d;
    logic [7:0]              csum_q, csum_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    accept;
    logic [15:0]             n_full;

    assign in_ready = (state_q == LEN0 || state_q == LEN1 || state_q == DATA || state_q == CHECK)
                      && !restart;
    assign accept   = in_valid && in_ready;
    assign n_full   = {in_data, len_lo_q};

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;

        if (restart) begin
            state_d    = LEN0;
            csum_d     = 8'd0;
            word_idx_d = '0;
            byte_cnt_d = 2'd0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            cpu_hold_d = 1'b1;
        end else if (accept) begin
            case (state_q)
                LEN0: begin
                    len_lo_d = in_data;
                    csum_d   = csum_q ^ in_data;
                    state_d  = LEN1;
                end
                LEN1: begin
                    csum_d = csum_q ^ in_data;
                    if ({1'b0, n_full} > MAX_WORDS) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (n_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        count_d = n_full[WI-1:0];
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // First three bytes are parked little-endian; the fourth completes the word.
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {word_idx_q[WI-2:0], 2'b00};
                        mem_wdata_d = {in_data, asm_q};
                        word_idx_d  = word_idx_q + 1'b1;
                        if (word_idx_q + 1'b1 == count_q) begin
                            state_d = CHECK;
                        end
                    end else begin
                        asm_d[8*byte_cnt_q +: 8] = in_data;
                    end
                end
                CHECK: begin
                    if (in_data == csum_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LEN0;
            len_lo_q    <= 8'd0;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= 2'd0;
            asm_q       <= 24'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-built images, write log captured from the
// memory port and compared against expected address/data lists.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    logic [31:0] expAddr[$];
    logic [31:0] expData[$];

    prog_loader #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Every memory write is logged on the falling edge, so a two-cycle pulse shows up twice.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            wrAddr.push_back(32'(mem_addr));
            wrData.push_back(mem_wdata);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Offers one byte from a falling edge and returns on the falling edge after it was taken.
    task automatic applyStimulus(input logic [7:0] b, input bit stall);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20 && !got; t++) begin
            #1 got = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
        if (stall) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic runStream(input bit stall);
        foreach (stream[i]) applyStimulus(stream[i], stall);
        in_valid = 1'b0;
    endtask

    task automatic setNominal(input logic [7:0] cs);
        stream  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, cs};
        expAddr = '{32'h0, 32'h4};
        expData = '{32'h00100513, 32'h00200593};
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
    endtask

    task automatic checkWrites(input string tag);
        logic [31:0] a;
        logic [31:0] d;
        checkOutput({tag, "_wr_count"}, 32'(wrAddr.size()), 32'(expAddr.size()));
        foreach (expAddr[i]) begin
            a = (i < wrAddr.size()) ? wrAddr[i] : 32'hDEADBEEF;
            d = (i < wrData.size()) ? wrData[i] : 32'hDEADBEEF;
            checkOutput({tag, "_wr_addr"}, a, expAddr[i]);
            checkOutput({tag, "_wr_data"}, d, expData[i]);
        end
    endtask

    // A byte is offered alongside restart to show it is refused.
    task automatic doRestart();
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1 checkOutput("restart_gates_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        #1 checkOutput("restart_ready", 32'(in_ready), 32'd1);
        checkOutput("restart_hold", 32'(cpu_hold), 32'd1);
        checkOutput("restart_done", 32'(done), 32'd0);
        checkOutput("restart_error", 32'(error), 32'd0);
        @(negedge clk);
    endtask

    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic checkError(input string tag);
        checkOutput({tag, "_error"}, 32'(error), 32'd1);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] cs;
        logic [7:0] b0, b1, b2, b3;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;

        #12;
        checkOutput("reset_we", 32'(mem_we), 32'd0);
        checkOutput("reset_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_wdata", mem_wdata, 32'd0);
        checkOutput("reset_hold", 32'(cpu_hold), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("reset_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        $display("[TB] nominal image");
        setNominal(8'hB2);
        clearLog();
        runStream(1'b0);
        checkDone("nom");
        checkWrites("nom");
        doRestart();

        $display("[TB] bad checksum");
        setNominal(8'hB3);
        clearLog();
        runStream(1'b0);
        checkError("badcs");
        checkWrites("badcs");
        doRestart();

        $display("[TB] empty image");
        stream = '{8'h00, 8'h00, 8'h00};
        expAddr.delete();
        expData.delete();
        clearLog();
        runStream(1'b0);
        checkDone("empty");
        checkWrites("empty");
        doRestart();

        $display("[TB] oversize length");
        stream = '{8'h01, 8'h01};
        clearLog();
        runStream(1'b0);
        checkError("over");
        checkWrites("over");
        doRestart();

        $display("[TB] maximum image");
        stream.delete();
        expAddr.delete();
        expData.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        cs = 8'h01;
        for (int i = 0; i < 256; i++) begin
            b0 = 8'(i);
            b1 = 8'(i) ^ 8'h5A;
            b2 = 8'hC3;
            b3 = 8'(i + 1);
            stream.push_back(b0);
            stream.push_back(b1);
            stream.push_back(b2);
            stream.push_back(b3);
            cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
            expAddr.push_back(32'(i * 4));
            expData.push_back({b3, b2, b1, b0});
        end
        stream.push_back(cs);
        clearLog();
        runStream(1'b0);
        checkDone("max");
        checkWrites("max");
        doRestart();

        $display("[TB] stalled source");
        setNominal(8'hB2);
        clearLog();
        runStream(1'b1);
        checkDone("stall");
        checkWrites("stall");
        doRestart();

        $display("[TB] restart mid payload");
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
        runStream(1'b0);
        doRestart();
        setNominal(8'hB2);
        clearLog();
        runStream(1'b0);
        checkDone("midrst");
        checkWrites("midrst");
        doRestart();

        $display("[TB] asynchronous reset");
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        runStream(1'b0);
        checkOutput("async_pre_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_we", 32'(mem_we), 32'd0);
        checkOutput("async_addr", 32'(mem_addr), 32'd0);
        checkOutput("async_hold", 32'(cpu_hold), 32'd1);
        checkOutput("async_done", 32'(done), 32'd0);
        checkOutput("async_error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        setNominal(8'hB2);
        clearLog();
        runStream(1'b0);
        checkDone("async");
        checkWrites("async");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that fills the CPU's instruction memory from a byte stream (e.g. a UART receiver). It is the writer side of the instruction-memory interface, which the CPU only reads. While loading, it holds the CPU in reset. It releases the CPU only after the whole image has arrived and its checksum has verified. It sits between the host-link byte source, the instruction memory write port and the CPU reset input.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction memory byte-address width; MAX_WORDS = 2**(ADDR_WIDTH-2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-low (rst=0 resets)
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready at a rising edge
- restart  in  1  synchronous pulse; abort or finish, then begin a new load
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_WIDTH  byte address of the word being written
- mem_wdata  out  32  word being written
- cpu_hold  out  1  held high to keep the CPU in reset
- done  out  1  image loaded and verified
- error  out  1  oversize length or checksum mismatch

## Operation
- Stream format:
  - 2-byte word count N, little-endian (16-bit).
  - N×4 payload bytes, each word little-endian: the first byte goes to wdata[7:0].
  - 1 checksum byte equal to the XOR of every preceding byte, including both length bytes.
- States and transitions:
  - LEN0 → LEN1: on each accepted byte, capture the count byte and XOR it into the running checksum.
  - From LEN1, on the second byte:
    - N > MAX_WORDS → ERROR
    - N = 0 → CHECK
    - otherwise → DATA
  - DATA:
    - Shift accepted bytes into a 4-byte assembly register and count them with a 2-bit byte counter.
    - On the 4th byte, issue a one-cycle write: mem_addr = 4×word_index, mem_wdata = assembled word.
    - Increment word_index; when word_index reaches N → CHECK.
  - CHECK: on the accepted byte, compare it with the running XOR.
    - Equal → DONE.
    - Unequal → ERROR.
  - DONE: cpu_hold=0, done=1, in_ready=0; stays here until restart or reset.
  - ERROR: cpu_hold=1, error=1, in_ready=0; stays here until restart or reset.
- in_ready = 1 in LEN0/LEN1/DATA/CHECK, gated low in any cycle where restart=1.
- restart in any state:
  - Next state LEN0; clear checksum, word_index, byte counter, done and error.
  - Set cpu_hold=1.
  - A byte presented in the same cycle is not accepted.
- N = MAX_WORDS is legal. The last address is 4×(MAX_WORDS−1); mem_addr never wraps.
- Bytes arriving while in_ready=0 are not consumed. The source must hold them.

## Timing
- Reset values, asserted immediately while rst=0:
  - state = LEN0
  - in_ready = 1 once rst deasserts
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - cpu_hold = 1, done = 0, error = 0
- All outputs except in_ready are registered.
- mem_we goes high in the cycle after the edge that accepted the 4th byte of a word, for exactly one cycle. mem_addr and mem_wdata are valid in that same cycle and hold their values afterwards.
- Back-to-back bytes (in_valid held high) are accepted at 1 byte/cycle with no bubbles.
- done/error and cpu_hold change in the cycle after the edge that accepted the checksum byte.
- For the ERROR case on length: error rises the cycle after the 2nd length byte is accepted.
- Reset mid-load (rst low at any time) aborts the load and returns all outputs to their reset values asynchronously. Memory already written is not cleared.

## Test plan
- Nominal 2-word image: send 02 00 13 05 10 00 93 05 20 00 B2 with in_valid held high.
  - Expect mem_we pulses: addr 0x000 / 0x00100513, then addr 0x004 / 0x00200593.
  - One cycle after B2 is accepted: done=1, cpu_hold=0, in_ready=0.
- Bad checksum: same stream with final byte B3.
  - Expect the same two writes, then error=1, cpu_hold=1, done=0, in_ready=0.
- Empty image: send 00 00 00.
  - Expect no mem_we pulses, then done=1, cpu_hold=0.
- Oversize image (ADDR_WIDTH=10): send 01 01 (N=257).
  - Expect error=1 the cycle after the 2nd byte, no mem_we, in_ready=0.
  - Then N=256: the last write is at addr 0x3FC and done=1.
- Stalls and restart:
  - Rerun the nominal stream with in_valid toggling every cycle; expect identical writes and done.
  - Pulse restart after 5 payload bytes, then send the full nominal stream; expect exactly the nominal writes (starting at addr 0) and done=1.
  - Pulse restart in DONE; expect cpu_hold=1, done=0, in_ready=1.
- Async reset: drop rst mid-DATA, between clock edges.
  - Expect mem_we=0, cpu_hold=1, done=0, error=0 immediately.
  - After release, the nominal stream loads correctly.
